div_seq_ctrl: RTL and testbench

- Multi-cycle control and sign-handling stage wrapped around the team's 32-bit combinational unsigned array divider.
- Accepts a signed or unsigned divide request and drives operand magnitudes to the divider.
- Holds them stable for a fixed multicycle window, then registers the divider's quotient/remainder with sign correction.
- Sits between the CPU execute stage and the HI/LO registers; presents busy/done handshake to the pipeline stall logic.

---
 rtl/div_pkg.sv | 15 +
 rtl/cond_negate.sv | 20 ++
 rtl/div_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_div_seq_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divide controller.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // Counter sized so LATENCY-1 fits for LATENCY up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation: out = neg ? -in : in (wrapping).
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);

  // Select between the operand and its wrapping negation.
  always_comb begin
    out = in;
    if (neg) begin
      out = {WIDTH{1'b0}} - in;
    end else begin
      out = in;
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multicycle sign-handling controller around an external combinational
// unsigned divider. Operand magnitudes are driven on dv_a/dv_b and held for
// LATENCY cycles before the divider result is sign-corrected and registered.
// Optional build macro: DIV_ZERO_FASTPATH_EN (divide-by-zero completes in
// one cycle with quotient all ones and the raw dividend as remainder).
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH   = DIV_WIDTH,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] dv_a,
  output logic [WIDTH-1:0] dv_b,
  input  logic [WIDTH-1:0] dv_q,
  input  logic [WIDTH-1:0] dv_r
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  div_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sign_q_r;
  logic             sign_r_r;
  logic             zero_r;

  logic             neg_a_s;
  logic             neg_b_s;
  logic             b_zero_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [WIDTH-1:0] fix_q_s;
  logic [WIDTH-1:0] fix_r_s;

  assign neg_a_s  = is_signed & a[WIDTH-1];
  assign neg_b_s  = is_signed & b[WIDTH-1];
  assign b_zero_s = (b == {WIDTH{1'b0}});

  cond_negate #(.WIDTH(WIDTH)) u_neg_dividend (.in(a),    .neg(neg_a_s),  .out(mag_a_s));
  cond_negate #(.WIDTH(WIDTH)) u_neg_divisor  (.in(b),    .neg(neg_b_s),  .out(mag_b_s));
  cond_negate #(.WIDTH(WIDTH)) u_neg_quotient (.in(dv_q), .neg(sign_q_r), .out(fix_q_s));
  cond_negate #(.WIDTH(WIDTH)) u_neg_remain   (.in(dv_r), .neg(sign_r_r), .out(fix_r_s));

  // Control FSM: accept request, hold operands for the settle window, then
  // capture the sign-corrected result so done/results appear together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      sign_q_r    <= 1'b0;
      sign_r_r    <= 1'b0;
      zero_r      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
      dv_a        <= {WIDTH{1'b0}};
      dv_b        <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sign_q_r <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r_r <= neg_a_s;
            zero_r   <= b_zero_s;
            dv_a     <= mag_a_s;
            dv_b     <= mag_b_s;
            cnt_r    <= CNT_LOAD;
            busy     <= 1'b1;
`ifdef DIV_ZERO_FASTPATH_EN
            if (b_zero_s) begin
              // Skip the settle window; result does not depend on the divider.
              quotient    <= {WIDTH{1'b1}};
              remainder   <= a;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state_r     <= FIX;
            end else begin
              state_r <= WAIT;
            end
`else
            state_r <= WAIT;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            // Divider has settled: register the result on entry to FIX.
            quotient    <= fix_q_s;
            remainder   <= fix_r_s;
            div_by_zero <= zero_r;
            done        <= 1'b1;
            state_r     <= FIX;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        FIX: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl with a behavioural model of the external
// divider and a reference model built from plain signed/unsigned arithmetic.
module tb_div_seq_ctrl;

  localparam int W   = 32;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder, dv_a, dv_b, dv_q, dv_r;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t sb_q[$];

  div_seq_ctrl #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero),
    .dv_a(dv_a), .dv_b(dv_b), .dv_q(dv_q), .dv_r(dv_r)
  );

  // External unsigned array divider: all-ones quotient and dividend remainder on /0.
  assign dv_q = (dv_b == 32'd0) ? 32'hFFFF_FFFF : dv_a / dv_b;
  assign dv_r = (dv_b == 32'd0) ? dv_a : dv_a % dv_b;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: truncating division, remainder takes the dividend's sign.
  function automatic logic [64:0] ref_div(input bit s, input logic [W-1:0] av, input logic [W-1:0] bv);
    longint sa, sb, q, r;
    if (bv == 32'd0) begin
`ifdef DIV_ZERO_FASTPATH_EN
      return {1'b1, 32'hFFFF_FFFF, av};
`else
      if (s && av[31]) return {1'b1, 32'h0000_0001, av};
      else             return {1'b1, 32'hFFFF_FFFF, av};
`endif
    end
    if (!s) return {1'b0, av / bv, av % bv};
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    q  = sa / sb;
    r  = sa % sb;
    return {1'b0, q[31:0], r[31:0]};
  endfunction

  function automatic int lat_of(input logic [W-1:0] bv);
`ifdef DIV_ZERO_FASTPATH_EN
    if (bv == 32'd0) return 1;
`endif
    return LAT + 1;
  endfunction

  // Monitor: every done must match the head of the scoreboard, on time.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(x.due));
        chk("quotient", 64'(quotient), 64'(x.q));
        chk("remainder", 64'(remainder), 64'(x.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(x.dbz));
      end
    end else if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
      chk("done_timeout", 64'd0, 64'd1);
      void'(sb_q.pop_front());
    end
  end

  task automatic run_op(input bit s, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit inj, input bit chk_busy);
    logic [64:0] e;
    exp_t x;
    int dk;
    e  = ref_div(s, av, bv);
    dk = lat_of(bv);
    @(negedge clk);
    if (chk_busy) chk("busy_c0", 64'(busy), 64'd0);
    is_signed = s; a = av; b = bv; start = 1'b1;
    x.dbz = e[64]; x.q = e[63:32]; x.r = e[31:0]; x.due = cyc + dk;
    sb_q.push_back(x);
    for (int k = 1; k <= dk + 1; k++) begin
      @(negedge clk);
      start = inj && (k == 2 || k == dk);
      if (start) begin
        a = $urandom; b = $urandom | 32'd1; is_signed = 1'($urandom);
      end
      if (chk_busy) chk("busy_window", 64'(busy), 64'(k <= dk));
      if (k == dk + 1) begin
        chk("hold_q", 64'(quotient), 64'(x.q));
        chk("hold_r", 64'(remainder), 64'(x.r));
        chk("hold_dbz", 64'(div_by_zero), 64'(x.dbz));
      end
    end
    start = 1'b0;
  endtask

  task automatic check_zero_state(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_q"}, 64'(quotient), 64'd0);
    chk({tag, "_r"}, 64'(remainder), 64'd0);
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
    chk({tag, "_dva"}, 64'(dv_a), 64'd0);
    chk({tag, "_dvb"}, 64'(dv_b), 64'd0);
  endtask

  task automatic run_reset_abort(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    is_signed = 1'b0; a = av; b = bv; start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 3) reset = 1'b1;
      if (k == 4) begin
        check_zero_state("abort");
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    check_zero_state("reset");
    reset = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 1'b0, 1'b1);
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b1);
    run_op(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(1'b0, 32'd55, 32'd0, 1'b0, 1'b1);
    run_op(1'b1, 32'hFFFF_FFC9, 32'd0, 1'b0, 1'b0);
    run_op(1'b0, 32'd1000, 32'd3, 1'b1, 1'b1);
    run_op(1'b0, 32'd77, 32'd5, 1'b0, 1'b0);
    run_reset_abort(32'd500, 32'd9);
    run_op(1'b1, 32'hFFFF_FC18, 32'd10, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] av, bv;
      int mode;
      mode = $urandom_range(0, 5);
      av = $urandom; bv = $urandom;
      case (mode)
        0: bv = 32'd0;
        1: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
        2: begin av = $urandom_range(0, 1000); bv = $urandom_range(1, 20); end
        3: bv = 32'($signed($urandom_range(0, 9)) - 5) | 32'd1;
        default: ;
      endcase
      run_op(1'($urandom), av, bv, (mode == 4) && (bv != 32'd0), 1'($urandom));
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
